// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war playfield: round state and winner encodings.
package tug_pkg;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      WIN_L = 2'd1,
      WIN_R = 2'd2
   } state_t;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b10;
   localparam logic [1:0] WIN_RIGHT = 2'b01;

endpackage

// File: rtl/tug_field_if.sv
// Player-facing bus of the tug-of-war block: buttons and restart in, playfield and scores out.
interface tug_field_if #(
   parameter int NUM_LIGHTS = 9,
   parameter int SCORE_W    = 3
);
   logic                  L;
   logic                  R;
   logic                  restart;
   logic [NUM_LIGHTS-1:0] lights;
   logic [1:0]            winner;
   logic [SCORE_W-1:0]    score_l;
   logic [SCORE_W-1:0]    score_r;

   modport master (output L, R, restart, input lights, winner, score_l, score_r);
   modport slave  (input L, R, restart, output lights, winner, score_l, score_r);
endinterface

// File: rtl/tug_edge.sv
// Rising-edge detector: one registered copy of the button, press = high now and low last edge.
module tug_edge (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);
   logic q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= 1'b0;
      else        q <= d;
   end

   assign rise = d & ~q;
endmodule

// File: rtl/tug_field.sv
// Tug-of-war playfield: presses push the lit position, reaching an end wins the round.
// Optional TUG_AUTO_RESTART_EN: win state returns to PLAY after HOLD_CYCLES edges.
module tug_field
   import tug_pkg::*;
#(
   parameter int NUM_LIGHTS  = 9,
   parameter int SCORE_W     = 3,
   parameter int HOLD_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   tug_field_if.slave  bus
);
   localparam int                 PW     = $clog2(NUM_LIGHTS);
   localparam logic [PW-1:0]      CENTER = PW'((NUM_LIGHTS - 1) / 2);
   localparam logic [PW-1:0]      LAST   = PW'(NUM_LIGHTS - 1);
   localparam logic [SCORE_W-1:0] SMAX   = '1;

   generate
      if (NUM_LIGHTS < 3 || (NUM_LIGHTS % 2) == 0) begin : g_bad_lights
         $error("tug_field: NUM_LIGHTS must be odd and >= 3");
      end
      if (HOLD_CYCLES < 1) begin : g_bad_hold
         $error("tug_field: HOLD_CYCLES must be >= 1");
      end
   endgenerate

   state_t             state, state_nx;
   logic [PW-1:0]      pos;
   logic [SCORE_W-1:0] sl, sr;
   logic               rise_l, rise_r, lp, rp, hold_done;

   tug_edge u_edge_l (.clk(clk), .reset(reset), .d(bus.L), .rise(rise_l));
   tug_edge u_edge_r (.clk(clk), .reset(reset), .d(bus.R), .rise(rise_r));

   // Simultaneous presses cancel out entirely.
   assign lp = rise_l & ~rise_r;
   assign rp = rise_r & ~rise_l;

`ifdef TUG_AUTO_RESTART_EN
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   logic [HW-1:0] hold_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              hold_cnt <= '0;
      else if (state == PLAY)  hold_cnt <= '0;
      else                     hold_cnt <= hold_cnt + HW'(1);
   end

   assign hold_done = (state != PLAY) && (hold_cnt == HW'(HOLD_CYCLES - 1));
`else
   assign hold_done = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= PLAY;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         PLAY: begin
            if (lp && pos == LAST)   state_nx = WIN_L;
            else if (rp && pos == '0) state_nx = WIN_R;
         end
         default: begin
            if (bus.restart || hold_done) state_nx = PLAY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos <= CENTER;
         sl  <= '0;
         sr  <= '0;
      end else if (state == PLAY) begin
         if (lp) begin
            if (pos != LAST)    pos <= pos + PW'(1);
            else if (sl != SMAX) sl <= sl + SCORE_W'(1);
         end
         if (rp) begin
            if (pos != '0)      pos <= pos - PW'(1);
            else if (sr != SMAX) sr <= sr + SCORE_W'(1);
         end
      end else if (state_nx == PLAY) begin
         pos <= CENTER;
      end
   end

   // Outputs decode registered state only, so no input reaches them combinationally.
   always_comb begin
      bus.lights  = '0;
      bus.winner  = WIN_NONE;
      bus.score_l = sl;
      bus.score_r = sr;
      case (state)
         PLAY:    bus.lights[pos] = 1'b1;
         WIN_L:   bus.winner      = WIN_LEFT;
         WIN_R:   bus.winner      = WIN_RIGHT;
         default: bus.winner      = WIN_NONE;
      endcase
   end
endmodule

// File: tb/tb_tug_field.sv
// Randomized self-checking bench for tug_field against a round-level reference model.
module tb_tug_field;
   localparam int N    = 5;
   localparam int SW   = 2;
   localparam int HOLD = 3;
   localparam int C    = (N - 1) / 2;
   localparam int SMAX = (1 << SW) - 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model: mode 0 playing, 1 left won, 2 right won
   int m_mode, m_pos, m_sl, m_sr, m_hold;
   bit m_prev_l, m_prev_r;

   tug_field_if #(.NUM_LIGHTS(N), .SCORE_W(SW)) bus ();

   tug_field #(.NUM_LIGHTS(N), .SCORE_W(SW), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pos = C; m_sl = 0; m_sr = 0; m_hold = 0;
      m_prev_l = 0; m_prev_r = 0;
   endtask

   task automatic model_step(input bit l, input bit r, input bit rs);
      bit pl, pr;
      pl = l && !m_prev_l;
      pr = r && !m_prev_r;
      m_prev_l = l;
      m_prev_r = r;
      if (m_mode == 0) begin
         m_hold = 0;
         if (pl && !pr) begin
            if (m_pos == N - 1) begin m_mode = 1; m_sl = (m_sl < SMAX) ? m_sl + 1 : SMAX; end
            else m_pos++;
         end else if (pr && !pl) begin
            if (m_pos == 0) begin m_mode = 2; m_sr = (m_sr < SMAX) ? m_sr + 1 : SMAX; end
            else m_pos--;
         end
      end else begin
         m_hold++;
         if (rs) begin m_mode = 0; m_pos = C; end
`ifdef TUG_AUTO_RESTART_EN
         else if (m_hold == HOLD) begin m_mode = 0; m_pos = C; end
`endif
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] el;
      el = (m_mode == 0) ? (N'(1) << m_pos) : '0;
      chk({tag, ".lights"},  32'(bus.lights), 32'(el));
      chk({tag, ".winner"},  32'(bus.winner), (m_mode == 1) ? 32'd2 : (m_mode == 2) ? 32'd1 : 32'd0);
      chk({tag, ".score_l"}, 32'(bus.score_l), 32'(m_sl));
      chk({tag, ".score_r"}, 32'(bus.score_r), 32'(m_sr));
   endtask

   // Inputs change between edges; outputs checked right after the change and after the edge.
   task automatic cyc(input string tag, input bit l, input bit r, input bit rs, input bit rst);
      @(negedge clk);
      bus.L = l; bus.R = r; bus.restart = rs; reset = rst;
      if (!rst) model_reset();
      #1 check_all({tag, ".mid"});
      @(posedge clk);
      if (rst) model_step(l, r, rs);
      #1 check_all({tag, ".edge"});
   endtask

   initial begin
      bus.L = 0; bus.R = 0; bus.restart = 0;
      model_reset();
      cyc("reset", 0, 0, 0, 0);
      cyc("release", 0, 0, 0, 1);

      repeat (4) cyc("hold_l", 1, 0, 0, 1);
      repeat (2) cyc("hold_l_rel", 0, 0, 0, 1);

      cyc("rst2", 0, 0, 0, 0);
      cyc("both", 1, 1, 0, 1);
      cyc("both_rel", 0, 0, 0, 1);

      repeat (3) begin
         cyc("l_press", 1, 0, 0, 1);
         cyc("l_gap", 0, 0, 0, 1);
      end
      cyc("restart", 0, 0, 1, 1);
      cyc("post_restart", 0, 0, 0, 1);

      repeat (4) begin
         repeat (3) begin
            cyc("r_press", 0, 1, 0, 1);
            cyc("r_gap", 0, 0, 0, 1);
         end
`ifdef TUG_AUTO_RESTART_EN
         repeat (3) cyc("auto_wait", 0, 0, 0, 1);
`else
         cyc("r_restart", 0, 0, 1, 1);
`endif
      end

      repeat (3) begin
         cyc("r_again", 0, 1, 0, 1);
         cyc("r_again_gap", 0, 0, 0, 1);
      end
      cyc("rst_in_win", 0, 0, 0, 0);

      cyc("held_rst", 1, 0, 0, 0);
      cyc("held_release", 1, 0, 0, 1);
      cyc("held_rel2", 0, 0, 0, 1);

      for (int i = 0; i < 3000; i++) begin
         cyc("rand",
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 249) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
